add_subt: RTL and testbench



---
 rtl/add_subt_pkg.sv | 11 +
 rtl/add_subt_if.sv | 30 +++
 rtl/add_subt_full_adder.sv | 13 +
 rtl/add_subt.sv | 52 +++++
 tb/tb_add_subt.sv | 137 +++++++++++++
 5 files changed

// File: rtl/add_subt_pkg.sv
// Shared constants and types for the add_subt adder/subtractor slice.
package add_subt_pkg;

  localparam int ADD_SUBT_WIDTH = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

endpackage

// File: rtl/add_subt_if.sv
// Operand/result bundle for add_subt; master drives operands, slave returns results.
interface add_subt_if
  import add_subt_pkg::*;
#(
  parameter int WIDTH = ADD_SUBT_WIDTH
);
  // No valid/ready: the slave accepts a new operation every clock and
  // presents its result exactly one clock later.
  logic [WIDTH-1:0] Input_1;
  logic [WIDTH-1:0] Input_2;
  logic             In;
  logic [WIDTH-1:0] Res;
  logic             Out;

  modport master (
    output Input_1,
    output Input_2,
    output In,
    input  Res,
    input  Out
  );

  modport slave (
    input  Input_1,
    input  Input_2,
    input  In,
    output Res,
    output Out
  );
endinterface

// File: rtl/add_subt_full_adder.sv
// One-bit combinational full adder, the cell of the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/add_subt.sv
// Registered two's-complement adder/subtractor: XOR-inverted B, ripple chain,
// one output register with synchronous active-high reset.
module add_subt
  import add_subt_pkg::*;
#(
  parameter int WIDTH = ADD_SUBT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  add_subt_if.slave    bus
);

  logic             sub_mode;
  logic [WIDTH-1:0] bm;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] res_d, res_q;
  logic             out_d, out_q;

  // Subtraction is A + ~B + 1: invert B and feed the mode bit in as carry.
  assign sub_mode = (mode_e'(bus.In) == MODE_SUB);
  assign bm       = bus.Input_2 ^ {WIDTH{sub_mode}};
  assign carry[0] = sub_mode;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a    (bus.Input_1[i]),
      .b    (bm[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign res_d = sum;
  assign out_d = carry[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      out_q <= 1'b0;
    end else begin
      res_q <= res_d;
      out_q <= out_d;
    end
  end

  assign bus.Res = res_q;
  assign bus.Out = out_q;

endmodule

// File: tb/tb_add_subt.sv
// Directed and exhaustive checks of add_subt against an independent arithmetic model.
module tb_add_subt;

  localparam int W = 4;

  logic clk;
  logic rst;

  add_subt_if #(.WIDTH(W)) bus_if ();

  add_subt #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst            = 1'b1;
    bus_if.Input_1 = '0;
    bus_if.Input_2 = '0;
    bus_if.In      = 1'b0;
  end

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];
  string      tag_q[$];
  int         n_vec  = 0;
  int         n_fail = 0;

  task automatic check_eq(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got Out=%0b Res=%h, expected Out=%0b Res=%h",
               tag, got[W], got[W-1:0], exp[W], exp[W-1:0]);
    end
  endtask

  // Arithmetic reference: {carry/not-borrow, result}.
  function automatic logic [W:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic m);
    if (!m) return {1'b0, a} + {1'b0, b};
    else    return {(a >= b), a - b};
  endfunction

  // ---------------- driver ----------------
  // At each falling edge: retire the result registered by the previous
  // rising edge, then drive the next vector.
  task automatic step(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic m, input string tag);
    @(negedge clk);
    if (exp_q.size() > 0)
      check_eq(tag_q.pop_front(), {bus_if.Out, bus_if.Res}, exp_q.pop_front());
    rst            = r;
    bus_if.Input_1 = a;
    bus_if.Input_2 = b;
    bus_if.In      = m;
    exp_q.push_back(r ? '0 : ref_model(a, b, m));
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    @(negedge clk);
    if (exp_q.size() > 0)
      check_eq(tag_q.pop_front(), {bus_if.Out, bus_if.Res}, exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held two cycles with live operands.
    step(1'b1, 4'hA, 4'h3, 1'b0, "reset_0");
    step(1'b1, 4'hA, 4'h3, 1'b0, "reset_1");

    // Directed vectors with hand-computed results.
    step(1'b0, 4'b1011, 4'h0, 1'b0, "add_trunc");
    step(1'b0, 4'hF, 4'h1, 1'b0, "add_ovf");
    step(1'b0, 4'h7, 4'h8, 1'b0, "add_7p8");
    step(1'b0, 4'h9, 4'h3, 1'b1, "sub_9m3");
    step(1'b0, 4'h3, 4'h9, 1'b1, "sub_3m9");
    step(1'b0, 4'h5, 4'h5, 1'b1, "sub_5m5");
    step(1'b0, 4'h0, 4'h0, 1'b1, "sub_0m0");
    step(1'b0, 4'h0, 4'h1, 1'b1, "sub_0m1");
    drain();

    // Hard-coded expectations for the directed block above.
    begin
      logic [W:0] hand [8];
      hand = '{5'h0B, 5'h10, 5'h0F, 5'h16, 5'h0A, 5'h10, 5'h10, 5'h0F};
      for (int i = 0; i < 8; i++) begin
        logic [W-1:0] a, b;
        logic         m;
        case (i)
          0: begin a = 4'hB; b = 4'h0; m = 1'b0; end
          1: begin a = 4'hF; b = 4'h1; m = 1'b0; end
          2: begin a = 4'h7; b = 4'h8; m = 1'b0; end
          3: begin a = 4'h9; b = 4'h3; m = 1'b1; end
          4: begin a = 4'h3; b = 4'h9; m = 1'b1; end
          5: begin a = 4'h5; b = 4'h5; m = 1'b1; end
          6: begin a = 4'h0; b = 4'h0; m = 1'b1; end
          default: begin a = 4'h0; b = 4'h1; m = 1'b1; end
        endcase
        step(1'b0, a, b, m, "hand_vec");
        exp_q[exp_q.size()-1] = hand[i];
      end
      drain();
    end

    // Back-to-back: fresh operands and alternating mode every cycle.
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom_range(0, 15));
      b = W'($urandom_range(0, 15));
      step(1'b0, a, b, i[0], "b2b");
    end

    // Exhaustive sweep with a reset pulse injected midway.
    for (int i = 0; i < 512; i++) begin
      if (i == 256)
        step(1'b1, 4'hF, 4'hF, 1'b0, "mid_reset");
      step(1'b0, i[3:0], i[7:4], i[8], "sweep");
    end
    drain();

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d results never retired, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
